// File: rtl/video_switch_sequencer_pkg.sv
// Purpose : shared state encodings, host_cfg bit indices and output reset values for the video switch sequencer.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package video_switch_sequencer_pkg;

  // FSM encodings (kept as plain constants so legacy code can share them)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_QUALIFY = 3'd1;
  localparam logic [2:0] ST_BLANK   = 3'd2;
  localparam logic [2:0] ST_SWITCH  = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;

  // host_cfg = {int_ext, rgb_comp, hd_sd}
  localparam int CFG_HD_SD    = 0;
  localparam int CFG_RGB_COMP = 1;
  localparam int CFG_INT_EXT  = 2;

  // Output values while in reset (also used by the monitor interface)
  localparam logic RST_VIDEO_OE_X = 1'b1;
  localparam logic RST_HD_SD_X    = 1'b0;
  localparam logic RST_RGB_COMP_X = 1'b1;
  localparam logic RST_INT_EXT_X  = 1'b1;

  // Counter width shared by the stability and settle counters; at least 1 bit
  function automatic int cnt_width(input int stable_cnt, input int settle_cnt);
    int m;
    m = (stable_cnt > settle_cnt) ? stable_cnt : settle_cnt;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/video_switch_sequencer_format_qualifier.sv
// Purpose : tracks the candidate video format and how long it has been held unchanged.
// Latency : o_stable asserts on the STABLE_CNT-th consecutive QUALIFY cycle with an unchanged format.
// Backpressure: none; the FSM decides whether to act on o_stable.
module video_switch_sequencer_format_qualifier
  import video_switch_sequencer_pkg::*;
#(
  parameter int FMT_W      = 8,
  parameter int STABLE_CNT = 2_500_000,
  parameter int CNT_W      = 22
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_active,
  input  logic [FMT_W-1:0] i_video_format,
  output logic [FMT_W-1:0] o_cand,
  output logic             o_stable
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);

  logic [FMT_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;

  // Load the candidate on QUALIFY entry; restart the count whenever the format moves, saturate at the end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_cand <= i_video_format;
      r_cnt  <= '0;
    end else if (i_active) begin
      if (i_video_format != r_cand) begin
        r_cand <= i_video_format;
        r_cnt  <= '0;
      end else if (r_cnt != STABLE_LAST) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cand   = r_cand;
  assign o_stable = i_active && (i_video_format == r_cand) && (r_cnt == STABLE_LAST);

endmodule

// File: rtl/video_switch_sequencer.sv
// Purpose : arbitrates host config writes and auto format changes, then blanks, switches, settles and re-enables video.
// Latency : host strobe to video enabled = 1 + SETTLE_CNT + 1 + SETTLE_CNT cycles.
// Backpressure: host writes during a switch are held in a one-deep pending register (latest wins).
module video_switch_sequencer
  import video_switch_sequencer_pkg::*;
#(
  parameter int STABLE_CNT = 2_500_000,
  parameter int SETTLE_CNT = 50_000,
  parameter int FMT_W      = 8
) (
  input  logic             i_clk_50mhz_in,
  input  logic             i_reset_x,
  input  logic [FMT_W-1:0] i_video_format,
  input  logic             i_auto_en,
  input  logic             i_host_cfg_valid,
  input  logic [2:0]       i_host_cfg,
  output logic             o_video_oe_x,
  output logic             o_hd_sd_x,
  output logic             o_rgb_comp_x,
  output logic             o_int_ext_x,
  output logic [FMT_W-1:0] o_cur_format,
  output logic             o_busy,
  output logic             o_switch_irq
);

  localparam int               CNT_W       = cnt_width(STABLE_CNT, SETTLE_CNT);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CNT - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_target;
  logic             r_auto;
  logic             r_pend_vld;
  logic [2:0]       r_pend_cfg;
  logic             r_video_oe_x;
  logic             r_hd_sd_x;
  logic             r_rgb_comp_x;
  logic             r_int_ext_x;
  logic [FMT_W-1:0] r_cur_format;
  logic             r_busy;
  logic             r_switch_irq;

  logic [2:0]       w_state_nxt;
  logic             w_host_vld;
  logic [2:0]       w_host_cfg;
  logic             w_settle_done;
  logic [FMT_W-1:0] w_cand;
  logic             w_stable;
  logic [2:0]       w_tgt_auto;
  logic [2:0]       w_cur_mode;
  logic             w_same_mode;

  // A fresh strobe is newer than anything pending, so it takes precedence
  assign w_host_vld    = i_host_cfg_valid | r_pend_vld;
  assign w_host_cfg    = i_host_cfg_valid ? i_host_cfg : r_pend_cfg;
  assign w_settle_done = (r_cnt == SETTLE_LAST);

  // Auto switches only change hd/sd; int/ext and rgb/comp are kept as they are
  assign w_cur_mode  = {r_int_ext_x, r_rgb_comp_x, r_hd_sd_x};
  assign w_tgt_auto  = {r_int_ext_x, r_rgb_comp_x, w_cand[0]};
  assign w_same_mode = (w_tgt_auto == w_cur_mode) && (w_cand != '0);

  video_switch_sequencer_format_qualifier #(
    .FMT_W      (FMT_W),
    .STABLE_CNT (STABLE_CNT),
    .CNT_W      (CNT_W)
  ) u_qual (
    .i_clk          (i_clk_50mhz_in),
    .i_rst_n        (i_reset_x),
    .i_start        ((r_state == ST_IDLE) && (w_state_nxt == ST_QUALIFY)),
    .i_active       (r_state == ST_QUALIFY),
    .i_video_format (i_video_format),
    .o_cand         (w_cand),
    .o_stable       (w_stable)
  );

  // Next-state selection: host requests always beat auto requests
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_host_vld)                                      w_state_nxt = ST_BLANK;
        else if (i_auto_en && (i_video_format != r_cur_format)) w_state_nxt = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (w_host_vld)      w_state_nxt = ST_BLANK;
        else if (!i_auto_en) w_state_nxt = ST_IDLE;
        else if (w_stable)   w_state_nxt = w_same_mode ? ST_IDLE : ST_BLANK;
      end
      ST_BLANK:  if (w_settle_done) w_state_nxt = ST_SWITCH;
      ST_SWITCH: w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (w_settle_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State, settle counter, pending host write and all registered outputs
  always_ff @(posedge i_clk_50mhz_in or negedge i_reset_x) begin
    if (!i_reset_x) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_target     <= '0;
      r_auto       <= 1'b0;
      r_pend_vld   <= 1'b0;
      r_pend_cfg   <= '0;
      r_video_oe_x <= RST_VIDEO_OE_X;
      r_hd_sd_x    <= RST_HD_SD_X;
      r_rgb_comp_x <= RST_RGB_COMP_X;
      r_int_ext_x  <= RST_INT_EXT_X;
      r_cur_format <= '0;
      r_busy       <= 1'b0;
      r_switch_irq <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_switch_irq <= 1'b0;
      // Counter restarts on every state change and saturates instead of wrapping
      if (w_state_nxt != r_state)  r_cnt <= '0;
      else if (r_cnt != SETTLE_LAST) r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (w_host_vld) begin
            r_target     <= w_host_cfg;
            r_auto       <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_video_oe_x <= 1'b1;
          end
        end
        ST_QUALIFY: begin
          if (w_host_vld) begin
            r_target     <= w_host_cfg;
            r_auto       <= 1'b0;
            r_video_oe_x <= 1'b1;
          end else if (i_auto_en && w_stable) begin
            if (w_same_mode) begin
              // Lines already match the new format: commit it without blanking
              r_cur_format <= w_cand;
              r_switch_irq <= 1'b1;
            end else begin
              r_target     <= w_tgt_auto;
              r_auto       <= 1'b1;
              r_video_oe_x <= 1'b1;
            end
          end
        end
        ST_SWITCH: begin
          r_hd_sd_x    <= r_target[CFG_HD_SD];
          r_rgb_comp_x <= r_target[CFG_RGB_COMP];
          r_int_ext_x  <= r_target[CFG_INT_EXT];
          if (r_auto) r_cur_format <= w_cand;
        end
        ST_SETTLE: begin
          if (w_settle_done) begin
            // Auto switch to "no signal" leaves the output disabled
            r_video_oe_x <= r_auto && (r_cur_format == '0);
            r_switch_irq <= 1'b1;
          end
        end
        default: ;
      endcase

      // Host writes arriving mid-switch are parked until the next IDLE cycle
      if (i_host_cfg_valid &&
          ((r_state == ST_BLANK) || (r_state == ST_SWITCH) || (r_state == ST_SETTLE))) begin
        r_pend_vld <= 1'b1;
        r_pend_cfg <= i_host_cfg;
      end
    end
  end

  assign o_video_oe_x = r_video_oe_x;
  assign o_hd_sd_x    = r_hd_sd_x;
  assign o_rgb_comp_x = r_rgb_comp_x;
  assign o_int_ext_x  = r_int_ext_x;
  assign o_cur_format = r_cur_format;
  assign o_busy       = r_busy;
  assign o_switch_irq = r_switch_irq;

endmodule

// File: tb/tb_video_switch_sequencer.sv
// Purpose : directed self-checking bench for video_switch_sequencer with STABLE_CNT=8, SETTLE_CNT=4.
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_video_switch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] video_format;
  logic       auto_en;
  logic       host_cfg_valid;
  logic [2:0] host_cfg;
  logic       video_oe_x, hd_sd_x, rgb_comp_x, int_ext_x, busy, switch_irq;
  logic [7:0] cur_format;

  int n_cmp  = 0;
  int n_fail = 0;

  video_switch_sequencer #(
    .STABLE_CNT (8),
    .SETTLE_CNT (4),
    .FMT_W      (8)
  ) dut (
    .i_clk_50mhz_in   (clk),
    .i_reset_x        (rst_n),
    .i_video_format   (video_format),
    .i_auto_en        (auto_en),
    .i_host_cfg_valid (host_cfg_valid),
    .i_host_cfg       (host_cfg),
    .o_video_oe_x     (video_oe_x),
    .o_hd_sd_x        (hd_sd_x),
    .o_rgb_comp_x     (rgb_comp_x),
    .o_int_ext_x      (int_ext_x),
    .o_cur_format     (cur_format),
    .o_busy           (busy),
    .o_switch_irq     (switch_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode lines packed as {int_ext, rgb_comp, hd_sd}
  function automatic logic [7:0] mode();
    return {5'd0, int_ext_x, rgb_comp_x, hd_sd_x};
  endfunction

  initial begin
    rst_n = 1'b0; video_format = 8'h00; auto_en = 1'b1;
    host_cfg_valid = 1'b0; host_cfg = 3'b000;

    // 1. reset and idle
    step(3);
    chk("rst_oe", video_oe_x, 8'd1);
    chk("rst_mode", mode(), 8'b110);
    rst_n = 1'b1;
    step(4);
    chk("idle_oe", video_oe_x, 8'd1);
    chk("idle_mode", mode(), 8'b110);
    chk("idle_cur", cur_format, 8'h00);
    chk("idle_busy", busy, 8'd0);
    chk("idle_irq", switch_irq, 8'd0);

    // 2. auto switch to HD format 01
    video_format = 8'h01;
    step(1);  chk("a_busy1", busy, 8'd1);
    step(7);  chk("a_qual_busy", busy, 8'd1);
    step(1);  chk("a_blank_busy", busy, 8'd1);  chk("a_blank_oe", video_oe_x, 8'd1);
    step(4);  chk("a_preswitch_mode", mode(), 8'b110);
    step(1);  chk("a_switch_mode", mode(), 8'b111); chk("a_switch_cur", cur_format, 8'h01);
              chk("a_switch_oe", video_oe_x, 8'd1);
    step(3);  chk("a_settle_oe", video_oe_x, 8'd1); chk("a_settle_irq", switch_irq, 8'd0);
    step(1);  chk("a_done_oe", video_oe_x, 8'd0); chk("a_done_irq", switch_irq, 8'd1);
              chk("a_done_busy", busy, 8'd0);
    step(1);  chk("a_irq_clear", switch_irq, 8'd0);

    // 3. format bouncing 02/01 every 5 cycles never qualifies
    for (int i = 0; i < 8; i++) begin
      video_format = (i % 2 == 0) ? 8'h02 : 8'h01;
      step(5);
      chk("bounce_busy", busy, 8'd1);
      chk("bounce_oe", video_oe_x, 8'd0);
      chk("bounce_mode", mode(), 8'b111);
      chk("bounce_irq", switch_irq, 8'd0);
    end

    // 4. host write pre-empts QUALIFY
    host_cfg_valid = 1'b1; host_cfg = 3'b010;
    step(1);  host_cfg_valid = 1'b0;
              chk("h_blank_oe", video_oe_x, 8'd1); chk("h_blank_busy", busy, 8'd1);
    step(4);  chk("h_preswitch_mode", mode(), 8'b111);
    step(1);  chk("h_switch_mode", mode(), 8'b010);
    step(3);  chk("h_settle_oe", video_oe_x, 8'd1);
    step(1);  chk("h_done_oe", video_oe_x, 8'd0); chk("h_done_irq", switch_irq, 8'd1);
              chk("h_done_busy", busy, 8'd0); chk("h_cur_kept", cur_format, 8'h01);
    step(2);  chk("h_idle_busy", busy, 8'd0);

    // 5. two host writes during SETTLE: only the latest is applied
    host_cfg_valid = 1'b1; host_cfg = 3'b111;
    step(1);  host_cfg_valid = 1'b0;
    step(5);  chk("p_first_mode", mode(), 8'b111);
    step(1);  host_cfg_valid = 1'b1; host_cfg = 3'b001;
    step(1);  host_cfg = 3'b110;
    step(1);  host_cfg_valid = 1'b0;
    step(1);  chk("p_first_oe", video_oe_x, 8'd0); chk("p_first_irq", switch_irq, 8'd1);
              chk("p_first_busy", busy, 8'd0);
    step(1);  chk("p_second_oe", video_oe_x, 8'd1); chk("p_second_busy", busy, 8'd1);
              chk("p_second_irq", switch_irq, 8'd0);
    step(4);  chk("p_preswitch_mode", mode(), 8'b111);
    step(1);  chk("p_second_mode", mode(), 8'b110);
    step(4);  chk("p_second_done_oe", video_oe_x, 8'd0); chk("p_second_irq2", switch_irq, 8'd1);
    step(3);  chk("p_no_third", busy, 8'd0); chk("p_final_mode", mode(), 8'b110);

    // host 001 so the mode lines differ from their reset values
    host_cfg_valid = 1'b1; host_cfg = 3'b001;
    step(1);  host_cfg_valid = 1'b0;
    step(9);  chk("m_mode", mode(), 8'b001); chk("m_oe", video_oe_x, 8'd0);
              chk("m_irq", switch_irq, 8'd1);

    // 6. asynchronous reset in the middle of BLANK
    video_format = 8'h00; host_cfg_valid = 1'b1; host_cfg = 3'b000;
    step(1);  host_cfg_valid = 1'b0;
    step(1);  chk("r_blank_busy", busy, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_oe", video_oe_x, 8'd1);
    chk("r_async_mode", mode(), 8'b110);
    chk("r_async_cur", cur_format, 8'h00);
    chk("r_async_busy", busy, 8'd0);
    chk("r_async_irq", switch_irq, 8'd0);
    step(1);  rst_n = 1'b1;
    step(3);  chk("r_post_busy", busy, 8'd0); chk("r_post_mode", mode(), 8'b110);

    // auto_en low: format change ignored
    auto_en = 1'b0; video_format = 8'h05;
    step(12); chk("ae_busy", busy, 8'd0); chk("ae_cur", cur_format, 8'h00);

    // same-mode auto switch (SD 02): commit without blanking
    auto_en = 1'b1; video_format = 8'h02;
    step(8);  chk("s_qual_busy", busy, 8'd1); chk("s_qual_cur", cur_format, 8'h00);
    step(1);  chk("s_cur", cur_format, 8'h02); chk("s_irq", switch_irq, 8'd1);
              chk("s_busy", busy, 8'd0); chk("s_oe", video_oe_x, 8'd1);
              chk("s_mode", mode(), 8'b110);

    // signal lost (format 0): full sequence, output stays disabled
    video_format = 8'h00;
    step(9);  chk("z_blank_busy", busy, 8'd1);
    step(5);  chk("z_cur", cur_format, 8'h00);
    step(4);  chk("z_irq", switch_irq, 8'd1); chk("z_oe", video_oe_x, 8'd1);
              chk("z_busy", busy, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
